// File: rtl/ram_init_sequencer.sv
// rtl/ram_init_sequencer.sv - DDR controller bring-up/recovery sequencer
// Optional RAM_INIT_RETRY_EN: bounded reset retries on calibration timeout instead of failing at once.
module ram_init_sequencer #(
  parameter int RESET_CYCLES  = 16,
  parameter int CALIB_TIMEOUT = 1000000,
  parameter int SETTLE_CYCLES = 8,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       clk_memory,
  input  logic       rst,
  input  logic       calib_done,
  input  logic       restart,
  output logic       mem_resetn,
  output logic       aresetn_memory,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_count
);

  localparam int CNT_MAX = (RESET_CYCLES > CALIB_TIMEOUT) ? RESET_CYCLES : CALIB_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int SET_W   = $clog2(SETTLE_CYCLES + 1);

  localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(CALIB_TIMEOUT - 1);
  localparam logic [SET_W-1:0] SETTLE_LAST  = SET_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_RESET_HOLD,
    ST_WAIT_CALIB,
    ST_SETTLE,
    ST_RUN,
    ST_FAIL
  } state_t;

  state_t           state;
  state_t           next_state;
  logic             calib_meta;
  logic             calib_sync;
  logic [CNT_W-1:0] cnt;
  logic [SET_W-1:0] settle_cnt;
  logic             cnt_clr;
  logic             settle_clr;
  logic             mem_resetn_d;
  logic             aresetn_memory_d;
  logic             ready_d;
  logic             fail_d;
`ifdef RAM_INIT_RETRY_EN
  logic             retry_inc;
  logic             retry_clr;
`endif

  always_ff @(posedge clk_memory or posedge rst) begin
    if (rst) begin
      calib_meta <= 1'b0;
      calib_sync <= 1'b0;
    end else begin
      calib_meta <= calib_done;
      calib_sync <= calib_meta;
    end
  end

  // cnt is shared: reset-hold length, then the calibration timeout, which keeps
  // running through SETTLE so a glitchy calibration cannot extend the deadline.
  always_ff @(posedge clk_memory or posedge rst) begin
    if (rst) begin
      state          <= ST_RESET_HOLD;
      cnt            <= '0;
      settle_cnt     <= '0;
      mem_resetn     <= 1'b0;
      aresetn_memory <= 1'b0;
      ready          <= 1'b0;
      fail           <= 1'b0;
    end else begin
      state <= next_state;
      if (cnt_clr)
        cnt <= '0;
      else if (cnt != '1)
        cnt <= cnt + CNT_W'(1);
      if (settle_clr)
        settle_cnt <= '0;
      else if (state == ST_SETTLE && settle_cnt != '1)
        settle_cnt <= settle_cnt + SET_W'(1);
      mem_resetn     <= mem_resetn_d;
      aresetn_memory <= aresetn_memory_d;
      ready          <= ready_d;
      fail           <= fail_d;
    end
  end

  always_comb begin
    next_state = state;
    cnt_clr    = 1'b0;
    settle_clr = 1'b0;
`ifdef RAM_INIT_RETRY_EN
    retry_inc  = 1'b0;
    retry_clr  = 1'b0;
`endif
    if (restart) begin
      next_state = ST_RESET_HOLD;
      cnt_clr    = 1'b1;
`ifdef RAM_INIT_RETRY_EN
      retry_clr  = 1'b1;
`endif
    end else begin
      case (state)
        ST_RESET_HOLD: begin
          if (cnt >= RESET_LAST) begin
            next_state = ST_WAIT_CALIB;
            cnt_clr    = 1'b1;
          end
        end
        ST_WAIT_CALIB: begin
          if (calib_sync) begin
            next_state = ST_SETTLE;
            settle_clr = 1'b1;
          end else if (cnt >= TIMEOUT_LAST) begin
`ifdef RAM_INIT_RETRY_EN
            if (retry_count < 4'(MAX_RETRIES)) begin
              next_state = ST_RESET_HOLD;
              cnt_clr    = 1'b1;
              retry_inc  = 1'b1;
            end else begin
              next_state = ST_FAIL;
            end
`else
            next_state = ST_FAIL;
`endif
          end
        end
        ST_SETTLE: begin
          if (!calib_sync) begin
            next_state = ST_WAIT_CALIB;
          end else if (settle_cnt >= SETTLE_LAST) begin
            next_state = ST_RUN;
`ifdef RAM_INIT_RETRY_EN
            retry_clr  = 1'b1;
`endif
          end
        end
        ST_RUN: begin
          if (!calib_sync) begin
            next_state = ST_RESET_HOLD;
            cnt_clr    = 1'b1;
          end
        end
        ST_FAIL: next_state = ST_FAIL;
        default: begin
          next_state = ST_RESET_HOLD;
          cnt_clr    = 1'b1;
        end
      endcase
    end
  end

  // Outputs are decoded from next_state so the registered copies change on the transition edge.
  always_comb begin
    mem_resetn_d     = 1'b1;
    aresetn_memory_d = 1'b0;
    ready_d          = 1'b0;
    fail_d           = 1'b0;
    case (next_state)
      ST_RESET_HOLD: mem_resetn_d = 1'b0;
      ST_RUN: begin
        aresetn_memory_d = 1'b1;
        ready_d          = 1'b1;
      end
      ST_FAIL: begin
        mem_resetn_d = 1'b0;
        fail_d       = 1'b1;
      end
      default: mem_resetn_d = 1'b1;
    endcase
  end

`ifdef RAM_INIT_RETRY_EN
  always_ff @(posedge clk_memory or posedge rst) begin
    if (rst)
      retry_count <= 4'd0;
    else if (retry_clr)
      retry_count <= 4'd0;
    else if (retry_inc)
      retry_count <= retry_count + 4'd1;
  end
`else
  assign retry_count = 4'd0;
`endif

endmodule

// File: tb/tb_ram_init_sequencer.sv
// tb/tb_ram_init_sequencer.sv - scoreboard bench for ram_init_sequencer
// Expected output changes (cycle, value) are queued by the stimulus and popped by the monitor.
module tb_ram_init_sequencer;

  logic       clk_memory = 1'b0;
  logic       rst = 1'b0;
  logic       calib_done;
  logic       restart;
  logic       mem_resetn;
  logic       aresetn_memory;
  logic       ready;
  logic       fail;
  logic [3:0] retry_count;

  typedef struct {
    int         cyc;
    logic [7:0] v;
    string      name;
  } exp_t;

  exp_t       exp_q[$];
  int         cyc = 0;
  int         n_asserts = 0;
  int         n_fail = 0;
  bit         done = 1'b0;
  logic [7:0] outv;

  // outv = {mem_resetn, aresetn_memory, ready, fail, retry_count}
  localparam logic [7:0] V_RH0   = 8'b0000_0000;
  localparam logic [7:0] V_RH1   = 8'b0000_0001;
  localparam logic [7:0] V_RH2   = 8'b0000_0010;
  localparam logic [7:0] V_WAIT0 = 8'b1000_0000;
  localparam logic [7:0] V_WAIT1 = 8'b1000_0001;
  localparam logic [7:0] V_WAIT2 = 8'b1000_0010;
  localparam logic [7:0] V_RUN   = 8'b1110_0000;
  localparam logic [7:0] V_FAIL0 = 8'b0001_0000;
  localparam logic [7:0] V_FAIL2 = 8'b0001_0010;

  assign outv = {mem_resetn, aresetn_memory, ready, fail, retry_count};

  ram_init_sequencer #(
    .RESET_CYCLES (16),
    .CALIB_TIMEOUT(100),
    .SETTLE_CYCLES(8),
    .MAX_RETRIES  (2)
  ) dut (
    .clk_memory    (clk_memory),
    .rst           (rst),
    .calib_done    (calib_done),
    .restart       (restart),
    .mem_resetn    (mem_resetn),
    .aresetn_memory(aresetn_memory),
    .ready         (ready),
    .fail          (fail),
    .retry_count   (retry_count)
  );

  always #5 clk_memory = ~clk_memory;
  always @(posedge clk_memory) cyc <= cyc + 1;

  task automatic goto(input int e);
    while (cyc < e) begin
      @(posedge clk_memory);
      #1;
    end
  endtask

  task automatic expect_at(input int e, input logic [7:0] v, input string name);
    exp_t x;
    x.cyc  = e;
    x.v    = v;
    x.name = name;
    exp_q.push_back(x);
  endtask

  // Stimulus: cycle t is the reset-release edge (rst deasserted just after it).
  initial begin
    int t;
    int f;
    int r;
    int r2;
    int f2;
    calib_done = 1'b0;
    restart    = 1'b0;
    #1 rst = 1'b1;
    goto(4);
    rst = 1'b0;
    t = 4;

    // normal bring-up, calib_done sampled high from edge 40
    expect_at(t + 16, V_WAIT0, "bringup_mem_resetn");
    goto(t + 39);
    calib_done = 1'b1;
    expect_at(t + 50, V_RUN, "bringup_ready");

    // calibration loss in RUN at edge 60
    goto(t + 59);
    calib_done = 1'b0;
    expect_at(t + 62, V_RH0, "loss_reset_hold");
    expect_at(t + 78, V_WAIT0, "loss_rewait");
    goto(t + 84);
    calib_done = 1'b1;
    expect_at(t + 95, V_RUN, "loss_rerun");

    // restart in RUN
    goto(t + 100);
    restart = 1'b1;
    expect_at(t + 101, V_RH0, "restart_in_run");
    goto(t + 101);
    restart = 1'b0;
    expect_at(t + 117, V_WAIT0, "restart_run_wait");
    expect_at(t + 126, V_RUN, "restart_run_rerun");

    // 4-cycle settle glitch, then stable calibration reaches RUN
    goto(t + 130);
    calib_done = 1'b0;
    expect_at(t + 133, V_RH0, "glitch1_reset_hold");
    expect_at(t + 149, V_WAIT0, "glitch1_wait");
    goto(t + 159);
    calib_done = 1'b1;
    goto(t + 163);
    calib_done = 1'b0;
    goto(t + 179);
    calib_done = 1'b1;
    expect_at(t + 190, V_RUN, "glitch1_run");

    // glitch, then timeout at the deadline set on WAIT_CALIB entry (t+219)
    goto(t + 200);
    calib_done = 1'b0;
    expect_at(t + 203, V_RH0, "glitch2_reset_hold");
    expect_at(t + 219, V_WAIT0, "glitch2_wait");
    goto(t + 229);
    calib_done = 1'b1;
    goto(t + 233);
    calib_done = 1'b0;
`ifdef RAM_INIT_RETRY_EN
    expect_at(t + 319, V_RH1, "glitch2_retry1");
    expect_at(t + 335, V_WAIT1, "glitch2_retry1_wait");
    expect_at(t + 435, V_RH2, "glitch2_retry2");
    expect_at(t + 451, V_WAIT2, "glitch2_retry2_wait");
    expect_at(t + 551, V_FAIL2, "glitch2_fail");
    f = t + 551;
`else
    expect_at(t + 319, V_FAIL0, "glitch2_fail");
    f = t + 319;
`endif

    // restart in FAIL, then restart coinciding with a timeout
    goto(f + 10);
    restart = 1'b1;
    expect_at(f + 11, V_RH0, "restart_in_fail");
    goto(f + 11);
    restart = 1'b0;
    r = f + 11;
    expect_at(r + 16, V_WAIT0, "restart_fail_wait");
    goto(r + 115);
    restart = 1'b1;
    expect_at(r + 116, V_RH0, "restart_beats_timeout");
    goto(r + 116);
    restart = 1'b0;
    r2 = r + 116;

    // timeout sequence from a fresh RESET_HOLD entry at r2
    expect_at(r2 + 16, V_WAIT0, "timeout_wait");
`ifdef RAM_INIT_RETRY_EN
    expect_at(r2 + 116, V_RH1, "timeout_retry1");
    expect_at(r2 + 132, V_WAIT1, "timeout_retry1_wait");
    expect_at(r2 + 232, V_RH2, "timeout_retry2");
    expect_at(r2 + 248, V_WAIT2, "timeout_retry2_wait");
    expect_at(r2 + 348, V_FAIL2, "timeout_fail");
    f2 = r2 + 348;
`else
    expect_at(r2 + 116, V_FAIL0, "timeout_fail");
    f2 = r2 + 116;
`endif

    // recover to RUN, then asynchronous reset between clock edges
    goto(f2 + 5);
    restart = 1'b1;
    expect_at(f2 + 6, V_RH0, "restart_fail2");
    goto(f2 + 6);
    restart    = 1'b0;
    calib_done = 1'b1;
    expect_at(f2 + 22, V_WAIT0, "recover_wait");
    expect_at(f2 + 31, V_RUN, "recover_run");
    goto(f2 + 40);
    #1;
    expect_at(f2 + 40, V_RH0, "async_reset_in_run");
    rst = 1'b1;
    goto(f2 + 45);
    rst = 1'b0;
    expect_at(f2 + 61, V_WAIT0, "post_reset_wait");
    expect_at(f2 + 70, V_RUN, "post_reset_run");
    goto(f2 + 80);
    done = 1'b1;
  end

  // Monitor: owns the counters; every output change must match the next queued expectation.
  initial begin
    logic [7:0] prev_v;
    exp_t       e;
    #3;
    n_asserts++;
    if (outv !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_values: got %b, required %b", outv, 8'h00);
    end
    prev_v = 8'h00;
    while (!done) begin
      @(negedge clk_memory);
      if (outv !== prev_v) begin
        n_asserts++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change: cycle %0d got %b, required no change from %b",
                   cyc, outv, prev_v);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.v !== outv) begin
            n_fail++;
            $display("FAIL %s: cycle %0d got %b, required %b at cycle %0d",
                     e.name, cyc, outv, e.v, e.cyc);
          end
        end
        prev_v = outv;
      end
      if (cyc > 50000) begin
        n_fail++;
        $display("FAIL watchdog: cycle %0d reached, required completion before 50000", cyc);
        break;
      end
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_asserts++;
      n_fail++;
      $display("FAIL %s: no change seen, required %b at cycle %0d", e.name, e.v, e.cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
